// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult_ctrl
// Brief    : Shift-and-add multiplier control and upper datapath; drives an
//            external right shift register that holds B and the low product.
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] multiplicand,
  input  logic [DATA_SIZE-1:0] multiplier,
  input  logic                 sr_q0,
  output logic                 sr_en,
  output logic                 sr_shift_load,
  output logic [DATA_SIZE-1:0] sr_d,
  output logic                 sr_d_shift,
  output logic [DATA_SIZE-1:0] prod_hi,
  output logic                 ready,
  output logic                 done
);

  localparam int                C_CNT_W    = $clog2(DATA_SIZE) + 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DATA_SIZE - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CALC = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] mcand_q, mcand_d;
  logic [DATA_SIZE-1:0] acc_q,   acc_d;
  logic [C_CNT_W-1:0]   cnt_q,   cnt_d;
  logic [DATA_SIZE:0]   w_sum;

  // One extra bit keeps the adder carry, which becomes the serial MSB of acc.
  assign w_sum = {1'b0, acc_q} + (sr_q0 ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= C_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (start) state_d = C_CALC;
      C_CALC:  if (cnt_q == C_CNT_LAST) state_d = C_DONE;
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      C_IDLE: begin
        if (start) begin
          mcand_d = multiplicand;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      C_CALC: begin
        acc_d = w_sum[DATA_SIZE:1];
        cnt_d = cnt_q + C_CNT_ONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    ready         = 1'b0;
    done          = 1'b0;
    sr_en         = 1'b0;
    sr_shift_load = 1'b0;
    sr_d_shift    = 1'b0;
    case (state_q)
      C_IDLE: begin
        ready = 1'b1;
        sr_en = start;
      end
      C_CALC: begin
        sr_en         = 1'b1;
        sr_shift_load = 1'b1;
        sr_d_shift    = w_sum[0];
      end
      C_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign sr_d    = multiplier;
  assign prod_hi = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// Bench for shift_add_mult_ctrl at DATA_SIZE 8 and 4, each attached to a
// behavioural right shift register; products checked against plain A*B.
module tb_shift_add_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       drv_start;
  logic [7:0] drv_a, drv_b;
  logic       sel4;

  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8, sr_q0_8, sr_en8, sr_sl8, sr_ds8, ready8, done8;
  logic [7:0] sr_d8, hi8, q8;
  assign start8  = drv_start & ~sel4;
  assign sr_q0_8 = q8[0];

  shift_add_mult_ctrl #(.DATA_SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .multiplicand(drv_a), .multiplier(drv_b), .sr_q0(sr_q0_8),
    .sr_en(sr_en8), .sr_shift_load(sr_sl8), .sr_d(sr_d8), .sr_d_shift(sr_ds8),
    .prod_hi(hi8), .ready(ready8), .done(done8)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q8 <= '0;
    else if (sr_en8) q8 <= sr_sl8 ? {sr_ds8, q8[7:1]} : sr_d8;
  end

  // 4-bit instance
  logic       start4, sr_q0_4, sr_en4, sr_sl4, sr_ds4, ready4, done4;
  logic [3:0] sr_d4, hi4, q4;
  assign start4  = drv_start & sel4;
  assign sr_q0_4 = q4[0];

  shift_add_mult_ctrl #(.DATA_SIZE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .multiplicand(drv_a[3:0]), .multiplier(drv_b[3:0]), .sr_q0(sr_q0_4),
    .sr_en(sr_en4), .sr_shift_load(sr_sl4), .sr_d(sr_d4), .sr_d_shift(sr_ds4),
    .prod_hi(hi4), .ready(ready4), .done(done4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q4 <= '0;
    else if (sr_en4) q4 <= sr_sl4 ? {sr_ds4, q4[3:1]} : sr_d4;
  end

  logic        w_done, w_ready;
  logic [15:0] w_prod;
  assign w_done  = sel4 ? done4  : done8;
  assign w_ready = sel4 ? ready4 : ready8;
  assign w_prod  = sel4 ? {8'h00, hi4, q4} : {hi8, q8};

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full multiply from IDLE; operands are scrambled after acceptance.
  task automatic mul(input bit w4, input logic [7:0] a, input logic [7:0] b, input string name);
    int          lat;
    int          n;
    bit          both;
    logic [15:0] exp;
    sel4 = w4;
    n    = w4 ? 4 : 8;
    exp  = w4 ? ({12'h000, a[3:0]} * {12'h000, b[3:0]}) : ({8'h00, a} * {8'h00, b});
    drv_a = a; drv_b = b; drv_start = 1'b1;
    @(posedge clk); #1;
    drv_start = 1'b0;
    drv_a = 8'($urandom); drv_b = 8'($urandom);
    chk({name, "_ready_drop"}, 32'(w_ready), 32'd0);
    lat  = 0;
    both = 1'b0;
    while (!w_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (w_done && w_ready) both = 1'b1;
      drv_a = 8'($urandom); drv_b = 8'($urandom);
    end
    chk({name, "_latency"}, 32'(lat), 32'(n));
    chk({name, "_product"}, 32'(w_prod), 32'(exp));
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'(w_done), 32'd0);
    chk({name, "_ready_back"}, 32'(w_ready), 32'd1);
    chk({name, "_no_overlap"}, 32'(both), 32'd0);
  endtask

  typedef struct {
    bit          w4;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 8'd13,  8'd11,  16'h008F, "m13x11"};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01, "m255x255"};
    vecs[2] = '{1'b0, 8'd0,   8'd200, 16'h0000, "m0x200"};
    vecs[3] = '{1'b0, 8'd200, 8'd0,   16'h0000, "m200x0"};
    vecs[4] = '{1'b0, 8'd255, 8'd1,   16'h00FF, "m255x1"};
    vecs[5] = '{1'b0, 8'd128, 8'd2,   16'h0100, "m128x2"};
    vecs[6] = '{1'b1, 8'd15,  8'd15,  16'h00E1, "n15x15"};
    vecs[7] = '{1'b1, 8'd0,   8'd15,  16'h0000, "n0x15"};

    rst = 1'b1; drv_start = 1'b0; drv_a = '0; drv_b = '0; sel4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   32'(ready8), 32'd1);
    chk("rst_done",    32'(done8),  32'd0);
    chk("rst_sr_en",   32'(sr_en8), 32'd0);
    chk("rst_prod_hi", 32'(hi8),    32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors: the product is also checked against the literal table value.
    for (int i = 0; i < 8; i++) begin
      mul(vecs[i].w4, vecs[i].a, vecs[i].b, vecs[i].name);
      chk({vecs[i].name, "_table"}, 32'(w_prod), 32'(vecs[i].exp));
    end

    // Start held high with operand churn during CALC: one 7*9 per 10 cycles.
    begin
      int cyc;
      int ndone;
      int first_done;
      int last_done;
      sel4 = 1'b0; ndone = 0; first_done = 0; last_done = 0;
      drv_a = 8'd7; drv_b = 8'd9; drv_start = 1'b1;
      for (cyc = 1; cyc <= 30; cyc++) begin
        @(posedge clk); #1;
        if (done8) begin
          ndone++;
          if (ndone == 1) first_done = cyc;
          last_done = cyc;
          chk("hold_product", 32'({hi8, q8}), 32'h003F);
          drv_a = 8'd7; drv_b = 8'd9;
        end else if (!ready8) begin
          drv_a = 8'($urandom); drv_b = 8'($urandom);
        end
      end
      drv_start = 1'b0;
      chk("hold_count",  32'(ndone), 32'd3);
      chk("hold_first",  32'(first_done), 32'd9);
      chk("hold_period", 32'(last_done - first_done), 32'd20);
      @(posedge clk); #1;
    end

    // Asynchronous reset during the 4th CALC cycle of 100*100.
    sel4 = 1'b0;
    drv_a = 8'd100; drv_b = 8'd100; drv_start = 1'b1;
    @(posedge clk); #1;
    drv_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_ready",   32'(ready8), 32'd1);
    chk("midrst_done",    32'(done8),  32'd0);
    chk("midrst_prod_hi", 32'(hi8),    32'd0);
    chk("midrst_sr_en",   32'(sr_en8), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    mul(1'b0, 8'd3, 8'd5, "after_rst");
    chk("after_rst_value", 32'({hi8, q8}), 32'h000F);

    for (int i = 0; i < 500; i++) mul(1'b0, 8'($urandom), 8'($urandom), "rand8");
    for (int i = 0; i < 500; i++) mul(1'b1, 8'($urandom), 8'($urandom), "rand4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
